// File: rtl/pipe_skid_stage_pkg.sv
// Shared pipeline-stage definitions: default NOP instruction
// and the stage occupancy encodings used by skid stages.
package pipe_skid_stage_pkg;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_st_e;

endpackage

// File: rtl/pipe_entry.sv
// One pipeline slot: valid flop plus instruction/address payload.
// Ports: clk, rstn, load_i, clr_i, inst_i, addr_i -> valid_o, inst_o, addr_o.
// clr_i wins over load_i; a cleared slot reverts to the reset payload.
module pipe_entry #(
    parameter int                INST_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter logic [INST_W-1:0] INST_RST = '0,
    parameter logic [ADDR_W-1:0] ADDR_RST = '0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              load_i,
    input  logic              clr_i,
    input  logic [INST_W-1:0] inst_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] addr_o
);

    logic              valid_q;
    logic [INST_W-1:0] inst_q;
    logic [ADDR_W-1:0] addr_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            inst_q  <= INST_RST;
            addr_q  <= ADDR_RST;
        end else if (clr_i) begin
            valid_q <= 1'b0;
            inst_q  <= INST_RST;
            addr_q  <= ADDR_RST;
        end else if (load_i) begin
            valid_q <= 1'b1;
            inst_q  <= inst_i;
            addr_q  <= addr_i;
        end
    end

    assign valid_o = valid_q;
    assign inst_o  = inst_q;
    assign addr_o  = addr_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline register with a 2-entry skid buffer and flush.
// Ports: clk, rstn, flush_i, in_valid_i/in_ready_o/inst_i/addr_i upstream,
// out_valid_o/out_ready_i/inst_o/addr_o downstream, stall_cnt_o/flush_cnt_o.
// Macro PIPE_STAT_EN enables the saturating stall/flush counters;
// without it both counter ports are tied to zero.
module pipe_skid_stage
    import pipe_skid_stage_pkg::*;
#(
    parameter int                INST_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(INST_NOP),
    parameter logic [ADDR_W-1:0] ADDR_RST = '0,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [INST_W-1:0] inst_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    logic              main_v, skid_v;
    logic [INST_W-1:0] main_inst, skid_inst, main_inst_d;
    logic [ADDR_W-1:0] main_addr, skid_addr, main_addr_d;
    logic              main_ld, main_clr, skid_ld, skid_clr, sel_skid;
    logic              in_fire, out_fire;
    stage_st_e         state;

    // Occupancy is held in the entry valid flops themselves.
    assign state = skid_v ? ST_TWO : (main_v ? ST_ONE : ST_EMPTY);

    assign in_ready_o = !skid_v;
    assign in_fire    = in_valid_i & in_ready_o;
    assign out_fire   = main_v & out_ready_i;

    always_comb begin
        main_ld  = 1'b0;
        main_clr = 1'b0;
        skid_ld  = 1'b0;
        skid_clr = 1'b0;
        sel_skid = 1'b0;
        if (flush_i) begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            unique case (1'b1)
                state == ST_EMPTY: main_ld = in_fire;
                state == ST_ONE: begin
                    if (in_fire && out_fire) main_ld  = 1'b1;
                    else if (out_fire)       main_clr = 1'b1;
                    else if (in_fire)        skid_ld  = 1'b1;
                end
                state == ST_TWO: begin
                    if (out_fire) begin
                        main_ld  = 1'b1;
                        sel_skid = 1'b1;
                        skid_clr = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign main_inst_d = sel_skid ? skid_inst : inst_i;
    assign main_addr_d = sel_skid ? skid_addr : addr_i;

    pipe_entry #(
        .INST_W(INST_W), .ADDR_W(ADDR_W),
        .INST_RST(NOP_INST), .ADDR_RST(ADDR_RST)
    ) u_main (
        .clk(clk), .rstn(rstn),
        .load_i(main_ld), .clr_i(main_clr),
        .inst_i(main_inst_d), .addr_i(main_addr_d),
        .valid_o(main_v), .inst_o(main_inst), .addr_o(main_addr)
    );

    pipe_entry #(
        .INST_W(INST_W), .ADDR_W(ADDR_W),
        .INST_RST(NOP_INST), .ADDR_RST(ADDR_RST)
    ) u_skid (
        .clk(clk), .rstn(rstn),
        .load_i(skid_ld), .clr_i(skid_clr),
        .inst_i(inst_i), .addr_i(addr_i),
        .valid_o(skid_v), .inst_o(skid_inst), .addr_o(skid_addr)
    );

    assign out_valid_o = main_v;
    assign inst_o      = main_v ? main_inst : NOP_INST;
    assign addr_o      = main_v ? main_addr : ADDR_RST;

`ifdef PIPE_STAT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (main_v && !out_ready_i && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush_i && flush_cnt_q != '1)
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed self-checking bench for pipe_skid_stage.
// Second instance with CNT_W=2 exercises counter saturation.
module tb_pipe_skid_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] inst_i;
    logic [31:0] addr_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] inst_o;
    logic [31:0] addr_o;
    logic [15:0] stall_cnt_o;
    logic [15:0] flush_cnt_o;

    logic        s_in_ready, s_out_valid;
    logic [31:0] s_inst, s_addr;
    logic [1:0]  s_stall, s_flush;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] TAG = 32'hABCD_0000;

    always #5 clk = ~clk;

    pipe_skid_stage dut (
        .clk(clk), .rstn(rstn), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .inst_i(inst_i), .addr_i(addr_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .inst_o(inst_o), .addr_o(addr_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    pipe_skid_stage #(.CNT_W(2)) dut_sat (
        .clk(clk), .rstn(rstn), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(s_in_ready),
        .inst_i(inst_i), .addr_i(addr_i),
        .out_valid_o(s_out_valid), .out_ready_i(out_ready_i),
        .inst_o(s_inst), .addr_o(s_addr),
        .stall_cnt_o(s_stall), .flush_cnt_o(s_flush)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] a,
                         input logic rdy, input logic fl);
        in_valid_i  = v;
        addr_i      = a;
        inst_i      = TAG | a;
        out_ready_i = rdy;
        flush_i     = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v,
                           input logic [31:0] a);
        chk({tag, "_valid"}, {31'b0, out_valid_o}, {31'b0, v});
        chk({tag, "_addr"}, addr_o, v ? a : 32'h0);
        chk({tag, "_inst"}, inst_o, v ? (TAG | a) : NOP);
    endtask

    initial begin
        rstn = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #12;
        chk_out("rst", 1'b0, 32'h0);
        chk("rst_rdy", {31'b0, in_ready_o}, 32'h1);
        chk("rst_stall", {16'b0, stall_cnt_o}, 32'h0);
        chk("rst_flush", {16'b0, flush_cnt_o}, 32'h0);
        rstn = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(4 * i), 1'b1, 1'b0);
            tick();
            chk_out($sformatf("stream%0d", i), 1'b1, 32'(4 * i));
            chk($sformatf("stream_rdy%0d", i), {31'b0, in_ready_o}, 32'h1);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        chk_out("drain", 1'b0, 32'h0);

        drive(1'b1, 32'h100, 1'b0, 1'b0);
        tick();
        chk_out("stall_a", 1'b1, 32'h100);
        chk("stall_rdy_a", {31'b0, in_ready_o}, 32'h1);
        drive(1'b1, 32'h104, 1'b0, 1'b0);
        tick();
        chk_out("stall_b", 1'b1, 32'h100);
        chk("stall_rdy_b", {31'b0, in_ready_o}, 32'h0);
        drive(1'b1, 32'h108, 1'b0, 1'b0);
        tick();
        chk_out("stall_hold", 1'b1, 32'h100);
        chk("stall_rdy_c", {31'b0, in_ready_o}, 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        chk_out("release_a", 1'b1, 32'h104);
        chk("release_rdy", {31'b0, in_ready_o}, 32'h1);
        tick();
        chk_out("release_b", 1'b0, 32'h0);

        drive(1'b1, 32'h200, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h204, 1'b0, 1'b0);
        tick();
        chk("two_rdy", {31'b0, in_ready_o}, 32'h0);
        drive(1'b1, 32'h208, 1'b1, 1'b1);
        #2;
        chk_out("flush_cycle", 1'b1, 32'h200);
        tick();
        chk_out("flush_two", 1'b0, 32'h0);
        chk("flush_two_rdy", {31'b0, in_ready_o}, 32'h1);

        drive(1'b1, 32'h300, 1'b1, 1'b0);
        tick();
        chk_out("pre_flush1", 1'b1, 32'h300);
        drive(1'b1, 32'h304, 1'b1, 1'b1);
        tick();
        chk_out("flush_one", 1'b0, 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        chk_out("flush_drop", 1'b0, 32'h0);

        drive(1'b1, 32'h400, 1'b1, 1'b0);
        tick();
        chk_out("sim_a", 1'b1, 32'h400);
        drive(1'b1, 32'h404, 1'b1, 1'b0);
        tick();
        chk_out("sim_b", 1'b1, 32'h404);
        chk("sim_rdy", {31'b0, in_ready_o}, 32'h1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        chk_out("sim_drain", 1'b0, 32'h0);

`ifdef PIPE_STAT_EN
        chk("stall_cnt", {16'b0, stall_cnt_o}, 32'd3);
        chk("flush_cnt", {16'b0, flush_cnt_o}, 32'd2);
`else
        chk("stall_cnt", {16'b0, stall_cnt_o}, 32'd0);
        chk("flush_cnt", {16'b0, flush_cnt_o}, 32'd0);
`endif

        drive(1'b1, 32'h500, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h504, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h508, 1'b0, 1'b0);
        tick();
        tick();
`ifdef PIPE_STAT_EN
        chk("sat_stall", {30'b0, s_stall}, 32'd3);
`else
        chk("sat_stall", {30'b0, s_stall}, 32'd0);
`endif
        chk_out("pre_rst", 1'b1, 32'h500);
        chk("pre_rst_rdy", {31'b0, in_ready_o}, 32'h0);
        #2;
        rstn = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 32'h0);
        chk("async_rst_rdy", {31'b0, in_ready_o}, 32'h1);
        chk("async_rst_stall", {16'b0, stall_cnt_o}, 32'h0);
        chk("async_rst_sat", {30'b0, s_stall}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
